// File: rtl/rr_arbiter_4to1_32.sv
// Round-robin arbiter: four 32-bit requesters share one registered valid/ready output stage.
// The winner is picked by a rotating priority pointer and routed through a 4:1 word mux.
module rr_arbiter_4to1_32 #(
    parameter logic [1:0] PRIO_RESET = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] a_data,
    input  logic [31:0] b_data,
    input  logic [31:0] c_data,
    input  logic [31:0] d_data,
    output logic [3:0]  gnt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_src,
    output logic [15:0] xfer_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] cnt_q, cnt_d;

    logic [1:0]  idx;
    logic [1:0]  cand;
    logic        found;
    logic [31:0] mux_out;
    logic        accept;
    logic        load;

    // load is gated by rst_n so no grant can escape while reset is held
    assign accept = (state_q == FULL) & out_ready;
    assign load   = rst_n & (|req) & ((state_q == EMPTY) | out_ready);

    always_comb begin
        idx   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    // mux_4to1_32: word select driven by the arbitration winner
    always_comb begin
        case (idx)
            2'd0:    mux_out = a_data;
            2'd1:    mux_out = b_data;
            2'd2:    mux_out = c_data;
            default: mux_out = d_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= PRIO_RESET;
            data_q  <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (accept && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        src_d  = src_q;
        cnt_d  = cnt_q;
        if (load) begin
            ptr_d  = idx + 2'd1;
            data_d = mux_out;
            src_d  = idx;
        end
        if (accept) cnt_d = cnt_q + 16'd1;
    end

    always_comb begin
        gnt = 4'b0000;
        if (load) gnt[idx] = 1'b1;
        out_valid  = (state_q == FULL);
        out_data   = data_q;
        out_src    = src_q;
        xfer_count = cnt_q;
    end

endmodule

// File: tb/tb_rr_arbiter_4to1_32.sv
// Bench for rr_arbiter_4to1_32: vector table plus hand-written sequences, expected
// register state queued when inputs are driven and compared after the clock edge.
module tb_rr_arbiter_4to1_32;

    localparam logic [31:0] DA = 32'hAAAA0000;
    localparam logic [31:0] DB = 32'hBBBB0001;
    localparam logic [31:0] DC = 32'hCAFE0002;
    localparam logic [31:0] DD = 32'hDDDD0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_data, b_data, c_data, d_data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic [15:0] xfer_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  gnt;
        logic        vld;
        logic [31:0] data;
        logic [1:0]  src;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic [1:0]  src;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    rr_arbiter_4to1_32 #(.PRIO_RESET(2'd0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive at negedge, check the combinational grant, then check registers after the edge
    task automatic step(input string nm, input logic [3:0] r, input logic rdy,
                        input logic [3:0] eg, input logic ev, input logic [31:0] ed,
                        input logic [1:0] es, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        req = r;
        out_ready = rdy;
        #1;
        check({nm, ".gnt"}, 32'(gnt), 32'(eg));
        sb.push_back('{ev, ed, es, ec});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({nm, ".valid"}, 32'(out_valid), 32'(e.vld));
        check({nm, ".cnt"}, 32'(xfer_count), 32'(e.cnt));
        if (e.vld) begin
            check({nm, ".data"}, out_data, e.data);
            check({nm, ".src"}, 32'(out_src), 32'(e.src));
        end
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 16'd0};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, DC,    2'd2, 16'd0};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, DC,    2'd2, 16'd0};
        vecs[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, DC,    2'd2, 16'd0};
        vecs[4]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, DA,    2'd0, 16'd1};
        vecs[5]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, DD,    2'd3, 16'd2};
        vecs[6]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, DA,    2'd0, 16'd3};
        vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, DA,    2'd0, 16'd4};
        vecs[8]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, DB,    2'd1, 16'd4};
        vecs[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, DB,    2'd1, 16'd4};
        vecs[10] = '{4'b0110, 1'b1, 4'b0100, 1'b1, DC,    2'd2, 16'd5};
        vecs[11] = '{4'b0010, 1'b1, 4'b0010, 1'b1, DB,    2'd1, 16'd6};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, DB,    2'd1, 16'd7};

        a_data = DA; b_data = DB; c_data = DC; d_data = DD;
        req = 4'hF; out_ready = 1'b0; rst_n = 1'b0;

        // Reset held with all requests asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst.gnt", 32'(gnt), 32'h0);
        check("rst.valid", 32'(out_valid), 32'h0);
        check("rst.cnt", 32'(xfer_count), 32'h0);
        check("rst.data", out_data, 32'h0);
        check("rst.src", 32'(out_src), 32'h0);
        @(negedge clk);
        req = 4'h0;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rdy, vecs[i].gnt,
                 vecs[i].vld, vecs[i].data, vecs[i].src, vecs[i].cnt);

        // Reset between edges while FULL
        step("full", 4'b0001, 1'b0, 4'b0001, 1'b1, DA, 2'd0, 16'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(out_valid), 32'h0);
        check("midrst.gnt", 32'(gnt), 32'h0);
        check("midrst.cnt", 32'(xfer_count), 32'h0);
        @(negedge clk);
        req = 4'h0;
        rst_n = 1'b1;

        // All four requesting: pointer restarts at PRIO_RESET and rotates
        for (int k = 0; k < 8; k++)
            step($sformatf("rr%0d", k), 4'hF, 1'b1, 4'b0001 << (k % 4), 1'b1,
                 (k % 4 == 0) ? DA : (k % 4 == 1) ? DB : (k % 4 == 2) ? DC : DD,
                 2'(k % 4), 16'(k));
        step("rr.drain", 4'h0, 1'b1, 4'b0000, 1'b0, DD, 2'd3, 16'd8);

        // Stall: held word must not follow a changing source
        step("stall0", 4'b0010, 1'b0, 4'b0010, 1'b1, DB, 2'd1, 16'd8);
        b_data = 32'hBBBB1111;
        for (int k = 1; k < 5; k++)
            step($sformatf("stall%0d", k), 4'b0010, 1'b0, 4'b0000, 1'b1, DB, 2'd1, 16'd8);
        step("stall.b2b", 4'b0010, 1'b1, 4'b0010, 1'b1, 32'hBBBB1111, 2'd1, 16'd9);
        step("stall.drain", 4'b0000, 1'b1, 4'b0000, 1'b0, DB, 2'd1, 16'd10);

        // Counter wrap
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'hF;
        out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        check("wrap.ffff", 32'(xfer_count), 32'h0000FFFF);
        @(posedge clk);
        #1;
        check("wrap.zero", 32'(xfer_count), 32'h0);
        check("wrap.valid", 32'(out_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
